// File: rtl/udp_echo_pkg.sv
// -----------------------------------------------------------------------------
// udp_echo_pkg
//   Shared types and constants for the UDP echo responder.
//   - state_e    : responder FSM states. DRAIN exists only when the
//                  UDP_ECHO_PORT_FILTER_EN macro is defined.
//   - udp_hdr_t  : captured received-datagram header (sender IP, ports, length)
//   - sat_inc    : 16-bit saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package udp_echo_pkg;

  localparam int UDP_HDR_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RX     = 3'd1,
    TX_HDR = 3'd2,
    TX     = 3'd3
`ifdef UDP_ECHO_PORT_FILTER_EN
    ,
    DRAIN  = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic [31:0] ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
  } udp_hdr_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/udp_echo_payload_ram.sv
// -----------------------------------------------------------------------------
// udp_echo_payload_ram
//   Simple dual-port synchronous RAM, DEPTH x 8, for the buffered payload.
//   Ports:
//     clk      in   clock
//     rst_n    in   async active-low reset (clears the read data register only)
//     wr_en    in   write strobe
//     wr_addr  in   write address
//     wr_data  in   write byte
//     rd_addr  in   read address, sampled every cycle
//     rd_data  out  registered read data: mem[rd_addr] of the previous cycle
// -----------------------------------------------------------------------------
module udp_echo_payload_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  // NOTE: the storage array has no reset so it maps onto block RAM; every
  // byte is written before it is read back, so its power-up contents never
  // reach the output.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/udp_echo_responder.sv
// -----------------------------------------------------------------------------
// udp_echo_responder
//   Store-and-forward UDP echo stage. Captures one received header, buffers the
//   whole payload, validates it (tuser error, length match, buffer fit) and
//   then emits a reply header (addresses/ports swapped, LOCAL_IP as source)
//   followed by the buffered payload. Bad datagrams are dropped, never echoed.
//
//   Build option: define UDP_ECHO_PORT_FILTER_EN to echo only datagrams sent
//   to ECHO_PORT; others are drained and counted as drops.
//
//   Ports:
//     udp_sys_clk, system_reset_n   clock, async active-low reset
//     rx_hdr_*  / rx_src_ip / rx_src_port / rx_dst_port / rx_length
//                                   received header handshake and fields
//     rx_t*                         received payload AXIS (tuser on tlast = bad)
//     tx_hdr_* / tx_src_ip / tx_dst_ip / tx_src_port / tx_dst_port / tx_length
//     tx_ttl / tx_dscp / tx_ecn / tx_checksum
//                                   reply header handshake and fields
//     tx_t*                         reply payload AXIS (tuser always 0)
//     echo_count, drop_count        saturating statistics
// -----------------------------------------------------------------------------
module udp_echo_responder
  import udp_echo_pkg::*;
#(
  parameter int          DEPTH     = 2048,
  parameter logic [31:0] LOCAL_IP  = 32'hC0A80180,
  parameter logic [15:0] ECHO_PORT = 16'd7,
  parameter logic [7:0]  TTL       = 8'd64
) (
  input  logic        udp_sys_clk,
  input  logic        system_reset_n,
  input  logic        rx_hdr_valid,
  output logic        rx_hdr_ready,
  input  logic [31:0] rx_src_ip,
  input  logic [15:0] rx_src_port,
  input  logic [15:0] rx_dst_port,
  input  logic [15:0] rx_length,
  input  logic [7:0]  rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready,
  input  logic        rx_tlast,
  input  logic        rx_tuser,
  output logic        tx_hdr_valid,
  input  logic        tx_hdr_ready,
  output logic [31:0] tx_src_ip,
  output logic [31:0] tx_dst_ip,
  output logic [15:0] tx_src_port,
  output logic [15:0] tx_dst_port,
  output logic [15:0] tx_length,
  output logic [7:0]  tx_ttl,
  output logic [5:0]  tx_dscp,
  output logic [1:0]  tx_ecn,
  output logic [15:0] tx_checksum,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  output logic        tx_tuser,
  output logic [15:0] echo_count,
  output logic [15:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  // Write pointer needs one extra bit so it can reach DEPTH (buffer full).
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  state_e        state_q, state_d;
  udp_hdr_t      hdr_q, hdr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   echo_cnt_q, echo_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  // Handshake outputs are registered copies of the next-state decode so they
  // come out of reset at 0 and never glitch.
  logic          rx_hdr_ready_q, rx_hdr_ready_d;
  logic          rx_tready_q, rx_tready_d;
  logic          tx_hdr_valid_q, tx_hdr_valid_d;
  logic          tx_tvalid_q, tx_tvalid_d;

  logic          ram_wr_en;
  logic [7:0]    ram_rd_data;
  logic          rx_beat;
  logic          tx_beat;
  logic          tx_last;
  logic [PW-1:0] bytes_now;
  logic          len_ok;
  logic          pkt_ok;

`ifndef UDP_ECHO_PORT_FILTER_EN
  logic unused_port_match;
  assign unused_port_match = (rx_dst_port == ECHO_PORT);
`endif

  assign rx_beat   = rx_tvalid & rx_tready_q;
  assign tx_beat   = tx_tvalid_q & tx_tready;
  assign tx_last   = ({1'b0, rd_ptr_q} == (wr_ptr_q - PW'(1)));
  // Byte count including the beat currently on the bus.
  assign bytes_now = wr_ptr_q + PW'(1);
  // The 17-bit subtraction keeps a length below 8 from aliasing onto a
  // small byte count.
  assign len_ok    = (hdr_q.length >= 16'(UDP_HDR_BYTES)) &&
                     (17'(bytes_now) == (17'(hdr_q.length) - 17'(UDP_HDR_BYTES)));
  assign pkt_ok    = !rx_tuser && !ovf_q && (wr_ptr_q != FULL) && len_ok;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q;
    echo_cnt_d = echo_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ram_wr_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_hdr_valid && rx_hdr_ready_q) begin
          hdr_d.ip       = rx_src_ip;
          hdr_d.src_port = rx_src_port;
          hdr_d.dst_port = rx_dst_port;
          hdr_d.length   = rx_length;
          wr_ptr_d       = '0;
          ovf_d          = 1'b0;
          state_d        = RX;
`ifdef UDP_ECHO_PORT_FILTER_EN
          if (rx_dst_port != ECHO_PORT) begin
            state_d = DRAIN;
          end
`endif
        end
      end

      RX: begin
        if (rx_beat) begin
          // Beats past the end of the buffer are swallowed but poison the packet.
          if (wr_ptr_q != FULL) begin
            ram_wr_en = 1'b1;
            wr_ptr_d  = bytes_now;
          end else begin
            ovf_d = 1'b1;
          end
          if (rx_tlast) begin
            if (pkt_ok) begin
              rd_ptr_d = '0;
              state_d  = TX_HDR;
            end else begin
              drop_cnt_d = sat_inc(drop_cnt_q);
              state_d    = IDLE;
            end
          end
        end
      end

      TX_HDR: begin
        if (tx_hdr_valid_q && tx_hdr_ready) begin
          state_d = TX;
        end
      end

      TX: begin
        if (tx_beat) begin
          if (tx_last) begin
            rd_ptr_d   = '0;
            echo_cnt_d = sat_inc(echo_cnt_q);
            state_d    = IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end

`ifdef UDP_ECHO_PORT_FILTER_EN
      DRAIN: begin
        if (rx_beat && rx_tlast) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = IDLE;
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    rx_hdr_ready_d = (state_d == IDLE);
    rx_tready_d    = (state_d == RX);
`ifdef UDP_ECHO_PORT_FILTER_EN
    if (state_d == DRAIN) begin
      rx_tready_d = 1'b1;
    end
`endif
    tx_hdr_valid_d = (state_d == TX_HDR);
    tx_tvalid_d    = (state_d == TX);
  end

  always_ff @(posedge udp_sys_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q        <= IDLE;
      hdr_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ovf_q          <= 1'b0;
      echo_cnt_q     <= '0;
      drop_cnt_q     <= '0;
      rx_hdr_ready_q <= 1'b0;
      rx_tready_q    <= 1'b0;
      tx_hdr_valid_q <= 1'b0;
      tx_tvalid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_q          <= hdr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      ovf_q          <= ovf_d;
      echo_cnt_q     <= echo_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
      rx_hdr_ready_q <= rx_hdr_ready_d;
      rx_tready_q    <= rx_tready_d;
      tx_hdr_valid_q <= tx_hdr_valid_d;
      tx_tvalid_q    <= tx_tvalid_d;
    end
  end

  // The read address follows rd_ptr_d, so the RAM's output register always
  // holds mem[rd_ptr_q]: the next byte is prefetched while the current one is
  // presented, and a stall simply re-reads the same address.
  udp_echo_payload_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (udp_sys_clk),
    .rst_n   (system_reset_n),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (rx_tdata),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rd_data)
  );

  assign rx_hdr_ready = rx_hdr_ready_q;
  assign rx_tready    = rx_tready_q;

  assign tx_hdr_valid = tx_hdr_valid_q;
  assign tx_src_ip    = LOCAL_IP;
  assign tx_dst_ip    = hdr_q.ip;
  assign tx_src_port  = hdr_q.dst_port;
  assign tx_dst_port  = hdr_q.src_port;
  // A datagram only reaches TX_HDR when its byte count equals length-8, so
  // the received length is also the reply length.
  assign tx_length    = hdr_q.length;
  assign tx_ttl       = TTL;
  assign tx_dscp      = '0;
  assign tx_ecn       = '0;
  assign tx_checksum  = '0;

  assign tx_tvalid    = tx_tvalid_q;
  assign tx_tdata     = tx_tvalid_q ? ram_rd_data : 8'h00;
  assign tx_tlast     = tx_tvalid_q & tx_last;
  assign tx_tuser     = 1'b0;

  assign echo_count   = echo_cnt_q;
  assign drop_count   = drop_cnt_q;

endmodule
